// File: rtl/train_controller.sv
// train_controller: sequences a perceptron training run over N_SAMPLES per epoch until convergence or MAX_EPOCHS.
module train_controller #(
  parameter int N_SAMPLES  = 150,
  parameter int MAX_EPOCHS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       mac_done,
  input  logic       err,
  output logic       inc_vector,
  output logic       init_weights,
  output logic       mac_start,
  output logic       ld_weights,
  output logic [7:0] sample_idx,
  output logic [7:0] epoch_cnt,
  output logic       busy,
  output logic       done,
  output logic       converged
);
  typedef enum logic [3:0] {
    IDLE, INIT, FETCH, SETTLE, START, WAIT, UPDATE, NEXT, EPOCH_END, DONE
  } state_t;
  state_t state_q, state_d;
  logic [7:0] idx_q, idx_d, ep_q, ep_d;
  logic chg_q, chg_d, conv_q, conv_d;
  logic [7:0] ep_inc;
  assign ep_inc = ep_q + 8'd1;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ep_d    = ep_q;
    chg_d   = chg_q;
    conv_d  = conv_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = INIT;
        idx_d   = '0;
        ep_d    = '0;
        chg_d   = 1'b0;
        conv_d  = 1'b0;
      end
      INIT:   state_d = FETCH;
      FETCH:  state_d = SETTLE;
      SETTLE: state_d = START;
      START:  state_d = WAIT;
      WAIT:   state_d = mac_done ? (err ? UPDATE : NEXT) : WAIT;
      UPDATE: begin
        chg_d   = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        state_d = (idx_q == 8'(N_SAMPLES - 1)) ? EPOCH_END : FETCH;
        idx_d   = (idx_q == 8'(N_SAMPLES - 1)) ? idx_q : idx_q + 8'd1;
      end
      EPOCH_END: begin
        ep_d    = ep_inc;
        conv_d  = !chg_q;
        state_d = (!chg_q || ep_inc == 8'(MAX_EPOCHS)) ? DONE : FETCH;
        chg_d   = (state_d == FETCH) ? 1'b0 : chg_q;
        idx_d   = (state_d == FETCH) ? 8'd0 : idx_q;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      ep_d    = '0;
      chg_d   = 1'b0;
      conv_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ep_q    <= '0;
      chg_q   <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ep_q    <= ep_d;
      chg_q   <= chg_d;
      conv_q  <= conv_d;
    end
  end
  // Every output is a pure decode of registered state, so pulses last exactly one state cycle.
  assign init_weights = (state_q == INIT);
  assign inc_vector   = (state_q == FETCH);
  assign mac_start    = (state_q == START);
  assign ld_weights   = (state_q == UPDATE);
  assign done         = (state_q == DONE);
  assign busy         = (state_q != IDLE) && (state_q != DONE);
  assign sample_idx   = idx_q;
  assign epoch_cnt    = ep_q;
  assign converged    = conv_q;
endmodule

// File: tb/tb_train_controller.sv
// tb_train_controller: directed checks of the training sequencer against a behavioural datapath responder.
module tb_train_controller;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, mac_done = 1'b0, err = 1'b0;
  logic inc_vector, init_weights, mac_start, ld_weights, busy, done, converged;
  logic [7:0] sample_idx, epoch_cnt;
  int n_pass = 0, n_tot = 0;
  int n_inc = 0, n_init = 0, n_ms = 0, n_ld = 0, n_dbl = 0;
  int mode = 0, stall = 0, wcnt = 0;
  logic glitch = 1'b0, pend = 1'b0;
  logic p_inc = 1'b0, p_init = 1'b0, p_ms = 1'b0, p_ld = 1'b0;
  int cyc;
  logic init_seen;
  logic [7:0] ep_seen;

  train_controller #(.N_SAMPLES(150), .MAX_EPOCHS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mac_done(mac_done), .err(err),
    .inc_vector(inc_vector), .init_weights(init_weights), .mac_start(mac_start),
    .ld_weights(ld_weights), .sample_idx(sample_idx), .epoch_cnt(epoch_cnt),
    .busy(busy), .done(done), .converged(converged)
  );

  always #5 clk = ~clk;

  // Datapath responder: mac_done arrives stall+1 cycles after mac_start; glitch adds stray mac_done/err.
  always @(negedge clk) begin
    mac_done = 1'b0;
    err = glitch;
    if (pend) begin
      if (wcnt == 0) begin
        mac_done = 1'b1;
        err = (mode == 2) || (mode == 1 && epoch_cnt == 0 && sample_idx == 0);
        pend = 1'b0;
      end else wcnt--;
    end
    if (mac_start) begin
      pend = 1'b1;
      wcnt = stall;
    end
    if (glitch && inc_vector) begin
      mac_done = 1'b1;
      err = 1'b1;
    end
    n_inc  += int'(inc_vector);
    n_init += int'(init_weights);
    n_ms   += int'(mac_start);
    n_ld   += int'(ld_weights);
    n_dbl  += int'((inc_vector && p_inc) || (init_weights && p_init) || (mac_start && p_ms) || (ld_weights && p_ld));
    p_inc = inc_vector; p_init = init_weights; p_ms = mac_start; p_ld = ld_weights;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_inc = 0; n_init = 0; n_ms = 0; n_ld = 0; n_dbl = 0;
  endtask

  // Pulse start for one edge, then count edges (including the sampling one) until done.
  task automatic run(input int budget, output int cycles, output logic iw, output logic [7:0] ep);
    start = 1'b1;
    tick();
    start = 1'b0;
    iw = init_weights;
    ep = epoch_cnt;
    cycles = 1;
    while (!done && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    // reset from a mid-run state
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat ($urandom_range(5, 300)) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pulses", {28'd0, inc_vector, init_weights, mac_start, ld_weights}, 0);
    chk("rst_idx", 32'(sample_idx), 0);
    chk("rst_epoch", 32'(epoch_cnt), 0);
    chk("rst_conv", 32'(converged), 0);
    pend = 1'b0;
    tick();
    // clean run
    clr();
    mode = 0;
    run(2000, cyc, init_seen, ep_seen);
    chk("clean_cycles", 32'(cyc), 753);
    chk("clean_init", 32'(n_init), 1);
    chk("clean_inc", 32'(n_inc), 150);
    chk("clean_ld", 32'(n_ld), 0);
    chk("clean_epoch", 32'(epoch_cnt), 1);
    chk("clean_conv", 32'(converged), 1);
    chk("clean_busy", 32'(busy), 0);
    chk("clean_idx_hold", 32'(sample_idx), 149);
    tick();
    chk("done_hold", {22'd0, done, epoch_cnt, converged}, {22'd0, 1'b1, 8'd1, 1'b1});
    // single error in first epoch, restarted from DONE
    clr();
    mode = 1;
    run(4000, cyc, init_seen, ep_seen);
    chk("restart_init", 32'(init_seen), 1);
    chk("restart_epoch0", 32'(ep_seen), 0);
    chk("one_err_ld", 32'(n_ld), 1);
    chk("one_err_inc", 32'(n_inc), 300);
    chk("one_err_epoch", 32'(epoch_cnt), 2);
    chk("one_err_conv", 32'(converged), 1);
    chk("one_err_done", 32'(done), 1);
    // always wrong: stops at epoch limit
    clr();
    mode = 2;
    run(5000, cyc, init_seen, ep_seen);
    chk("max_ld", 32'(n_ld), 450);
    chk("max_inc", 32'(n_inc), 450);
    chk("max_epoch", 32'(epoch_cnt), 3);
    chk("max_conv", 32'(converged), 0);
    chk("max_done", 32'(done), 1);
    // abort in WAIT at sample 37, with an ignored start mid-run
    clr();
    mode = 0;
    stall = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(mac_start && sample_idx == 8'd37) && cyc < 2000) begin
      if (sample_idx == 8'd10 && inc_vector) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
    end
    chk("abort_reach", 32'(cyc < 2000), 1);
    chk("busy_start_ignored", 32'(n_init), 1);
    tick();
    chk("abort_pre_busy", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_idx", 32'(sample_idx), 0);
    chk("abort_epoch", 32'(epoch_cnt), 0);
    repeat (10) tick();
    chk("abort_stays_idle", {30'd0, busy, done}, 0);
    // long stalls plus stray mac_done/err outside WAIT
    clr();
    stall = 20;
    glitch = 1'b1;
    run(8000, cyc, init_seen, ep_seen);
    glitch = 1'b0;
    chk("stall_cycles", 32'(cyc), 3753);
    chk("stall_mac_start", 32'(n_ms), 150);
    chk("stall_ld", 32'(n_ld), 0);
    chk("stall_conv", 32'(converged), 1);
    chk("no_double_pulse", 32'(n_dbl), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/train_controller.md
TRAIN_CONTROLLER -- requirements
Module: train_controller

Interface
REQ-001 Parameter N_SAMPLES, default 150: samples per epoch; equals the data loader's memory depth.
REQ-002 Parameter MAX_EPOCHS, default 100: epoch limit; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begin a training run; sampled in IDLE and DONE only.
REQ-006 abort  input  1  synchronous stop of a run; sampled in every state.
REQ-007 mac_done  input  1  datapath finished evaluating the current sample.
REQ-008 err  input  1  datapath mismatch flag; valid only in the cycle mac_done=1.
REQ-009 inc_vector  output  1  one-cycle pulse telling the data loader to present the next Vect_X/Vect_Y.
REQ-010 init_weights  output  1  one-cycle pulse that clears the datapath weights.
REQ-011 mac_start  output  1  one-cycle pulse that starts datapath evaluation.
REQ-012 ld_weights  output  1  one-cycle pulse that commits the weight update.
REQ-013 sample_idx  output  8  index of the sample in flight, 0..N_SAMPLES-1.
REQ-014 epoch_cnt  output  8  number of completed epochs.
REQ-015 busy  output  1  high in every state except IDLE and DONE.
REQ-016 done  output  1  high while in DONE.
REQ-017 converged  output  1  valid while done=1; 1 means the final epoch made no weight change.

Function
REQ-018 FSM states: IDLE, INIT, FETCH, SETTLE, START, WAIT, UPDATE, NEXT, EPOCH_END, DONE.
REQ-019 IDLE with start=1: go to INIT; otherwise stay in IDLE.
REQ-020 INIT: init_weights=1; clear sample_idx, epoch_cnt, the changed flag and converged; go to FETCH.
REQ-021 FETCH: inc_vector=1 for this cycle only; go to SETTLE.
REQ-022 SETTLE: hold one cycle so the loader's registered outputs are valid; go to START.
REQ-023 START: mac_start=1 for this cycle only; go to WAIT.
REQ-024 WAIT: mac_done is sampled from the cycle after mac_start onward.
REQ-025 WAIT with mac_done=0: stay in WAIT; the wait is unbounded.
REQ-026 WAIT with mac_done=1 and err=1: go to UPDATE.
REQ-027 WAIT with mac_done=1 and err=0: go to NEXT.
REQ-028 UPDATE: ld_weights=1 for one cycle; set the changed flag; go to NEXT.
REQ-029 NEXT with sample_idx=N_SAMPLES-1: go to EPOCH_END.
REQ-030 NEXT otherwise: increment sample_idx and go to FETCH.
REQ-031 Exactly N_SAMPLES inc_vector pulses are issued per epoch, so the loader's modulo-N pointer stays aligned with sample_idx.
REQ-032 EPOCH_END: increment epoch_cnt.
REQ-033 EPOCH_END with changed=0: set converged=1 and go to DONE.
REQ-034 EPOCH_END with changed=1 and the new epoch_cnt=MAX_EPOCHS: set converged=0 and go to DONE.
REQ-035 EPOCH_END otherwise: clear changed, clear sample_idx and go to FETCH.
REQ-036 DONE: hold epoch_cnt, sample_idx and converged; start=1 goes to INIT.
REQ-037 start while busy=1 is ignored.
REQ-038 abort=1 in any state: next state is IDLE; clear the counters, changed and converged.
REQ-039 abort has priority over start, mac_done and every other transition.
REQ-040 All pulse outputs are Moore outputs, decoded from state only; none asserts in two consecutive cycles.
REQ-041 mac_done outside WAIT is ignored.
REQ-042 err without mac_done is ignored.

Reset
REQ-043 When rst=1 at a clock edge, the next state is IDLE, whatever the current state.
REQ-044 On reset, all outputs, both counters, changed and converged become 0.
REQ-045 rst has priority over abort and start.
REQ-046 Reset mid-run drives no further pulses; the loader must be reset together with this block to realign.

Verification
REQ-047 Reset: rst=1 for 2 cycles from a random state -> all outputs 0; state IDLE.
REQ-048 Clean data, err=0 always, mac_done 1 cycle after mac_start: start pulse -> 1 init_weights, 150 inc_vector, 0 ld_weights.
REQ-049 Same run -> epoch_cnt=1, converged=1, done rises 753 cycles after start is sampled (INIT + 150x5 + EPOCH_END + 1).
REQ-050 err=1 only on sample 0 of epoch 1 -> exactly 1 ld_weights and 300 inc_vector; done with epoch_cnt=2, converged=1.
REQ-051 err=1 always, MAX_EPOCHS=3 -> 450 ld_weights; done with epoch_cnt=3, converged=0.
REQ-052 abort asserted in WAIT at sample_idx=37 -> IDLE next cycle; busy=0, done=0, sample_idx=0.
REQ-053 start during that run before the abort -> ignored.
REQ-054 start in DONE -> INIT, then init_weights pulse and epoch_cnt cleared to 0.
REQ-055 Stalls: mac_done held low 20 cycles -> stays in WAIT with no extra mac_start.
REQ-056 Stalls: a mac_done pulse in FETCH -> ignored.
